// File: rtl/calc_entry_fsm.sv
// Operand/operator entry controller for the two-digit BCD calculator.
// Qualifies key events, shifts digits into A/B, latches the operator and sequences SHOW.
module calc_entry_fsm #(
   parameter int         NDIG   = 2,
   parameter logic [3:0] NO_KEY = 4'hF
) (
   input  logic       fcrystal,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [8:0] key_code,
   input  logic       key_is_down,
   input  logic [3:0] number,
   input  logic       add,
   input  logic       subtract,
   input  logic       multiply,
   input  logic       enter,
   input  logic       clear,
   output logic [3:0] a1,
   output logic [3:0] a0,
   output logic [3:0] b1,
   output logic [3:0] b0,
   output logic [1:0] mode,
   output logic [2:0] state,
   output logic       result_valid
);

   typedef enum logic [2:0] {
      ENTER_A = 3'd0,
      ENTER_B = 3'd1,
      SHOW    = 3'd2
   } state_t;

   localparam logic [1:0] CNT_MAX = 2'(NDIG);

   state_t     state_reg;
   logic       kv_prev_reg;
   logic       held_reg;
   logic [8:0] held_code_reg;
   logic [1:0] cnt_a_reg;
   logic [1:0] cnt_b_reg;

   logic       accept;
   logic       is_repeat;
   logic       do_key;
   logic       is_digit;
   logic       is_op;
   logic [1:0] op_mode;

   // A level held on key_valid counts once: only the rising edge is an event.
   assign accept    = key_valid & ~kv_prev_reg;
   assign is_repeat = held_reg && (key_code == held_code_reg);
   assign do_key    = accept && key_is_down && !is_repeat;
   assign is_digit  = (number != NO_KEY) && (number <= 4'd9);
   assign is_op     = add | subtract | multiply;
   assign op_mode   = add ? 2'b00 : (subtract ? 2'b01 : 2'b10);
   assign state     = state_reg;

   always_ff @(posedge fcrystal or posedge rst) begin
      if (rst) begin
         state_reg     <= ENTER_A;
         kv_prev_reg   <= 1'b0;
         held_reg      <= 1'b0;
         held_code_reg <= 9'd0;
         cnt_a_reg     <= 2'd0;
         cnt_b_reg     <= 2'd0;
         a1            <= 4'd0;
         a0            <= 4'd0;
         b1            <= 4'd0;
         b0            <= 4'd0;
         mode          <= 2'b00;
         result_valid  <= 1'b0;
      end else begin
         kv_prev_reg <= key_valid;

         if (accept) begin
            if (key_is_down) begin
               if (!is_repeat) begin
                  held_reg      <= 1'b1;
                  held_code_reg <= key_code;
               end
            end else if (key_code == held_code_reg) begin
               held_reg <= 1'b0;
            end
         end

         if (do_key) begin
            if (clear) begin
               a1           <= 4'd0;
               a0           <= 4'd0;
               b1           <= 4'd0;
               b0           <= 4'd0;
               mode         <= 2'b00;
               cnt_a_reg    <= 2'd0;
               cnt_b_reg    <= 2'd0;
               state_reg    <= ENTER_A;
               result_valid <= 1'b0;
            end else if (is_digit) begin
               case (state_reg)
                  ENTER_A: begin
                     if (cnt_a_reg < CNT_MAX) begin
                        if (cnt_a_reg != 2'd0) a1 <= a0;
                        a0        <= number;
                        cnt_a_reg <= cnt_a_reg + 2'd1;
                     end
                  end
                  ENTER_B: begin
                     if (cnt_b_reg < CNT_MAX) begin
                        if (cnt_b_reg != 2'd0) b1 <= b0;
                        b0        <= number;
                        cnt_b_reg <= cnt_b_reg + 2'd1;
                     end
                  end
                  SHOW: begin
                     // A new digit after a result starts a fresh calculation, keeping the operator.
                     a1           <= 4'd0;
                     a0           <= number;
                     cnt_a_reg    <= 2'd1;
                     b1           <= 4'd0;
                     b0           <= 4'd0;
                     cnt_b_reg    <= 2'd0;
                     state_reg    <= ENTER_A;
                     result_valid <= 1'b0;
                  end
                  default: begin
                     state_reg    <= ENTER_A;
                     result_valid <= 1'b0;
                  end
               endcase
            end else if (is_op) begin
               if (state_reg == ENTER_A && cnt_a_reg != 2'd0) begin
                  mode      <= op_mode;
                  state_reg <= ENTER_B;
               end else if (state_reg == ENTER_B && cnt_b_reg == 2'd0) begin
                  mode <= op_mode;
               end
            end else if (enter) begin
               if (state_reg == ENTER_B && cnt_b_reg != 2'd0) begin
                  state_reg    <= SHOW;
                  result_valid <= 1'b1;
               end
            end
         end

         // Recover from any unused encoding regardless of key activity.
         if (state_reg != ENTER_A && state_reg != ENTER_B && state_reg != SHOW) begin
            state_reg    <= ENTER_A;
            result_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm: directed scenarios then random key events,
// checked against an arithmetic model of the entry rules.
module tb_calc_entry_fsm;

   logic       fcrystal;
   logic       rst;
   logic       key_valid;
   logic [8:0] key_code;
   logic       key_is_down;
   logic [3:0] number;
   logic       add, subtract, multiply, enter, clear;
   logic [3:0] a1, a0, b1, b0;
   logic [1:0] mode;
   logic [2:0] state;
   logic       result_valid;

   int errors = 0;
   int checks = 0;

   // Model: operands as integers 0..99, digit counts, phase 0/1/2.
   int m_a, m_b, m_ca, m_cb, m_mode, m_ph;
   bit m_held;
   int m_hcode;

   calc_entry_fsm dut (
      .fcrystal(fcrystal), .rst(rst), .key_valid(key_valid), .key_code(key_code),
      .key_is_down(key_is_down), .number(number), .add(add), .subtract(subtract),
      .multiply(multiply), .enter(enter), .clear(clear), .a1(a1), .a0(a0), .b1(b1),
      .b0(b0), .mode(mode), .state(state), .result_valid(result_valid)
   );

   initial fcrystal = 1'b0;
   always #5 fcrystal = ~fcrystal;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_mode = 0; m_ph = 0;
      m_held = 0; m_hcode = 0;
   endtask

   // fn bits: {clear, enter, multiply, subtract, add}
   task automatic model_apply(input int code, input bit down, input int num, input logic [4:0] fn);
      int opm;
      if (!down) begin
         if (code == m_hcode) m_held = 0;
         return;
      end
      if (m_held && code == m_hcode) return;
      m_held = 1; m_hcode = code;
      if (fn[4]) begin
         m_a = 0; m_b = 0; m_ca = 0; m_cb = 0; m_mode = 0; m_ph = 0;
      end else if (num <= 9) begin
         if (m_ph == 0) begin
            if (m_ca < 2) begin m_a = (m_a * 10 + num) % 100; m_ca++; end
         end else if (m_ph == 1) begin
            if (m_cb < 2) begin m_b = (m_b * 10 + num) % 100; m_cb++; end
         end else begin
            m_a = num; m_ca = 1; m_b = 0; m_cb = 0; m_ph = 0;
         end
      end else if (fn[2:0] != 3'b000) begin
         opm = fn[0] ? 0 : (fn[1] ? 1 : 2);
         if (m_ph == 0 && m_ca > 0) begin m_mode = opm; m_ph = 1; end
         else if (m_ph == 1 && m_cb == 0) m_mode = opm;
      end else if (fn[3]) begin
         if (m_ph == 1 && m_cb > 0) m_ph = 2;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " a1"}, 32'(a1), 32'(m_a / 10));
      chk({tag, " a0"}, 32'(a0), 32'(m_a % 10));
      chk({tag, " b1"}, 32'(b1), 32'(m_b / 10));
      chk({tag, " b0"}, 32'(b0), 32'(m_b % 10));
      chk({tag, " mode"}, 32'(mode), 32'(m_mode));
      chk({tag, " state"}, 32'(state), 32'(m_ph));
      chk({tag, " rv"}, 32'(result_valid), 32'(m_ph == 2));
      $display("%s: a=%0d%0d b=%0d%0d mode=%0d state=%0d rv=%0b (model a=%0d b=%0d)",
               tag, a1, a0, b1, b0, mode, state, result_valid, m_a, m_b);
   endtask

   task automatic idle_inputs();
      key_valid = 0; key_code = 9'd0; key_is_down = 0; number = 4'hF;
      add = 0; subtract = 0; multiply = 0; enter = 0; clear = 0;
   endtask

   task automatic drive(input int code, input bit down, input int num, input logic [4:0] fn);
      key_code = 9'(code); key_is_down = down; number = 4'(num);
      add = fn[0]; subtract = fn[1]; multiply = fn[2]; enter = fn[3]; clear = fn[4];
   endtask

   // kind 0-9 digit, 10 add, 11 sub, 12 mul, 13 enter, 14 clear, 15 junk number
   task automatic kind_decode(input int kind, output int code, output int num, output logic [4:0] fn);
      code = 16 + kind;
      num  = (kind <= 9) ? kind : ((kind == 15) ? int'($urandom_range(10, 14)) : 15);
      fn   = 5'b0;
      if (kind >= 10 && kind <= 14) fn[kind - 10] = 1'b1;
   endtask

   task automatic key_evt(input int code, input bit down, input int num,
                          input logic [4:0] fn, input string tag);
      @(negedge fcrystal);
      drive(code, down, num, fn);
      key_valid = 1;
      @(posedge fcrystal); #1;
      model_apply(code, down, num, fn);
      check_all(tag);
      @(negedge fcrystal);
      idle_inputs();
      @(posedge fcrystal);
   endtask

   task automatic press(input int kind, input bit down, input string tag);
      int code, num;
      logic [4:0] fn;
      kind_decode(kind, code, num, fn);
      key_evt(code, down, num, fn, tag);
   endtask

   task automatic tap(input int kind, input string tag);
      press(kind, 1'b1, {tag, " make"});
      press(kind, 1'b0, {tag, " break"});
   endtask

   initial begin
      int kind, last_kind, code, num;
      logic [4:0] fn;
      bit down;

      idle_inputs();
      rst = 1;
      model_reset();
      repeat (3) @(posedge fcrystal);
      #1 check_all("reset");
      @(negedge fcrystal) rst = 0;
      @(posedge fcrystal); #1 check_all("after reset");

      // T1: third digit ignored
      tap(4, "T1 4"); tap(7, "T1 7"); tap(2, "T1 2");
      chk("T1 a1 const", 32'(a1), 32'd4);
      chk("T1 a0 const", 32'(a0), 32'd7);

      // T2: 12 + 34 Enter
      tap(14, "T2 clr");
      tap(1, "T2 1"); tap(2, "T2 2"); tap(10, "T2 +");
      tap(3, "T2 3"); tap(4, "T2 4"); press(13, 1'b1, "T2 enter");
      chk("T2 state const", 32'(state), 32'd2);
      chk("T2 rv const", 32'(result_valid), 32'd1);
      chk("T2 b const", 32'({b1, b0}), 32'h34);
      press(13, 1'b0, "T2 enter break");

      // T3: typematic repeats suppressed
      tap(14, "T3 clr");
      repeat (4) press(5, 1'b1, "T3 5 repeat");
      press(5, 1'b0, "T3 5 break");
      chk("T3 a const", 32'({a1, a0}), 32'h05);

      // T4: operator replaced before B digits, frozen after
      tap(14, "T4 clr");
      tap(9, "T4 9"); tap(11, "T4 -"); tap(12, "T4 *"); tap(3, "T4 3");
      tap(10, "T4 + late"); tap(13, "T4 enter");
      chk("T4 mode const", 32'(mode), 32'd2);

      // T5: digit from SHOW restarts entry
      tap(6, "T5 6");
      chk("T5 state const", 32'(state), 32'd0);
      chk("T5 a const", 32'({a1, a0}), 32'h06);

      // Priority: digit beats add on the same event
      tap(14, "P clr");
      key_evt(40, 1'b1, 3, 5'b00001, "P digit+add");
      key_evt(40, 1'b0, 3, 5'b00001, "P break");
      tap(15, "P junk");

      // T6: level key_valid counts once, then rst mid-entry of B
      tap(14, "T6 clr");
      @(negedge fcrystal);
      kind_decode(8, code, num, fn);
      drive(code, 1'b1, num, fn);
      key_valid = 1;
      model_apply(code, 1'b1, num, fn);
      repeat (5) @(posedge fcrystal);
      #1 check_all("T6 level 8");
      @(negedge fcrystal) idle_inputs();
      @(posedge fcrystal);
      press(8, 1'b0, "T6 8 break");
      tap(10, "T6 +"); tap(1, "T6 1");
      @(negedge fcrystal);
      kind_decode(2, code, num, fn);
      drive(code, 1'b1, num, fn);
      key_valid = 1;
      rst = 1;
      model_reset();
      #1 check_all("T6 rst async");
      @(posedge fcrystal); #1 check_all("T6 rst held");
      @(negedge fcrystal) begin rst = 0; idle_inputs(); end
      @(posedge fcrystal); #1 check_all("T6 post rst");

      // Random key traffic
      last_kind = 0;
      for (int i = 0; i < 250; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 55)      kind = int'($urandom_range(0, 9));
         else if (r < 62) kind = 10;
         else if (r < 67) kind = 11;
         else if (r < 72) kind = 12;
         else if (r < 86) kind = 13;
         else if (r < 89) kind = 14;
         else             kind = 15;
         down = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 3) == 0) begin kind = last_kind; down = 1; end
         kind_decode(kind, code, num, fn);
         if ($urandom_range(0, 7) == 0) fn = fn | 5'($urandom_range(0, 31));
         key_evt(code, down, num, fn, $sformatf("R%0d k%0d", i, kind));
         last_kind = kind;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
